// File: rtl/dc_offset_remover.sv
// dc_offset_remover: subtracts a slewed DC offset from the audio stream and
// saturates the result to 16 bits, one cycle after each audio strobe.
// Optional feature macro: DC_OFFSET_SLEW_EN. When it is defined, the applied
// offset walks toward each new target by at most SLEW_STEP per sample. When
// it is undefined, a new offset is applied immediately.
module dc_offset_remover #(
    parameter int SLEW_STEP = 4
) (
    input  logic        audio_clk,
    input  logic        rst_in,
    input  logic        audio_trigger,
    input  logic [15:0] audio_in,
    input  logic [15:0] offset_in,
    input  logic        offset_valid,
    input  logic        bypass_in,
    output logic [15:0] audio_out,
    output logic        audio_out_valid,
    output logic        settled
);

`ifdef DC_OFFSET_SLEW_EN
    localparam bit SLEW_EN = 1'b1;
`else
    localparam bit SLEW_EN = 1'b0;
`endif

    localparam logic [16:0] STEP17 = 17'(SLEW_STEP);

    typedef enum logic [1:0] {IDLE, SLEWING, LOCKED} state_t;

    state_t      state_q, state_d;
    logic [15:0] target_q, target_d;
    logic [15:0] applied_q, applied_d;
    logic [15:0] audio_out_q, audio_out_d;
    logic        out_vld_q;

    // Slew step: gap is taken at 17 bits so the full signed range cannot wrap.
    // The stepped value always lies between applied and target, so 16 bits
    // are enough to hold it.
    logic signed [16:0] gap;
    logic        [16:0] gap_mag;
    logic        [15:0] step_mag;
    logic        [15:0] stepped;

    // Distance to target, clamped to SLEW_STEP, applied in the right direction
    always_comb begin
        gap      = $signed({target_q[15], target_q}) - $signed({applied_q[15], applied_q});
        gap_mag  = gap[16] ? 17'(-gap) : 17'(gap);
        step_mag = (gap_mag < STEP17) ? gap_mag[15:0] : STEP17[15:0];
        stepped  = gap[16] ? (applied_q - step_mag) : (applied_q + step_mag);
    end

    // State register and offset registers
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            state_q   <= IDLE;
            target_q  <= '0;
            applied_q <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            applied_q <= applied_d;
        end
    end

    // Next state: a new offset always wins over a same-cycle slew step,
    // which is why the step is only taken when offset_valid is low.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        applied_d = applied_q;
        if (offset_valid) begin
            target_d = offset_in;
            if (SLEW_EN) begin
                state_d = (offset_in != applied_q) ? SLEWING : LOCKED;
            end else begin
                applied_d = offset_in;
                state_d   = LOCKED;
            end
        end else if (state_q == SLEWING && audio_trigger) begin
            applied_d = stepped;
            if (stepped == target_q)
                state_d = LOCKED;
        end
    end

    // Settled is a function of the registered state only
    always_comb begin
        settled = (state_q != SLEWING);
    end

    // Corrected sample uses applied as it was before any same-edge update
    logic signed [16:0] diff;
    logic        [15:0] sat;
    always_comb begin
        diff = $signed({audio_in[15], audio_in}) - $signed({applied_q[15], applied_q});
        if (diff[16] != diff[15])
            sat = diff[16] ? 16'h8000 : 16'h7fff;
        else
            sat = diff[15:0];
        audio_out_d = audio_out_q;
        if (audio_trigger)
            audio_out_d = bypass_in ? audio_in : sat;
    end

    // Output registers: sample held between triggers, valid is a single pulse
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            audio_out_q <= '0;
            out_vld_q   <= 1'b0;
        end else begin
            audio_out_q <= audio_out_d;
            out_vld_q   <= audio_trigger;
        end
    end

    assign audio_out       = audio_out_q;
    assign audio_out_valid = out_vld_q;

endmodule

// File: tb/tb_dc_offset_remover.sv
// Randomized bench for dc_offset_remover with an integer reference model.
module tb_dc_offset_remover;

    localparam int STEP = 4;

    logic        audio_clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        audio_trigger = 1'b0;
    logic [15:0] audio_in = '0;
    logic [15:0] offset_in = '0;
    logic        offset_valid = 1'b0;
    logic        bypass_in = 1'b0;
    logic [15:0] audio_out;
    logic        audio_out_valid;
    logic        settled;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_target = 0, m_applied = 0, m_out = 0;
    bit m_vld = 0, m_slewing = 0;

`ifdef DC_OFFSET_SLEW_EN
    localparam bit SLEW = 1'b1;
`else
    localparam bit SLEW = 1'b0;
`endif

    dc_offset_remover #(.SLEW_STEP(STEP)) dut (
        .audio_clk       (audio_clk),
        .rst_in          (rst_in),
        .audio_trigger   (audio_trigger),
        .audio_in        (audio_in),
        .offset_in       (offset_in),
        .offset_valid    (offset_valid),
        .bypass_in       (bypass_in),
        .audio_out       (audio_out),
        .audio_out_valid (audio_out_valid),
        .settled         (settled)
    );

    always #5 audio_clk = ~audio_clk;

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, compare all outputs after the edge
    task automatic cyc(input bit r, input bit trig, input int ain, input bit ov,
                       input int off, input bit byp);
        int d, s;
        rst_in        = r;
        audio_trigger = trig;
        audio_in      = 16'(ain);
        offset_valid  = ov;
        offset_in     = 16'(off);
        bypass_in     = byp;
        if (r) begin
            m_target = 0; m_applied = 0; m_out = 0; m_vld = 0; m_slewing = 0;
        end else begin
            m_vld = trig;
            if (trig) m_out = byp ? ain : clamp16(ain - m_applied);
            if (ov) begin
                m_target = off;
                if (SLEW) m_slewing = (off != m_applied);
                else begin m_applied = off; m_slewing = 0; end
            end else if (trig && m_slewing) begin
                d = m_target - m_applied;
                s = (d < 0 ? -d : d);
                if (s > STEP) s = STEP;
                m_applied = (d < 0) ? m_applied - s : m_applied + s;
                if (m_applied == m_target) m_slewing = 0;
            end
        end
        @(posedge audio_clk);
        #1;
        check("audio_out", int'($signed(audio_out)), m_out);
        check("audio_out_valid", int'(audio_out_valid), int'(m_vld));
        check("settled", int'(settled), int'(!m_slewing));
    endtask

    task automatic trig(input int ain);
        cyc(0, 1, ain, 0, 0, 0);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    // Apply an offset and run triggers until the model has settled
    task automatic lock_to(input int off);
        int n;
        cyc(0, 0, 0, 1, off, 0);
        n = 0;
        while (m_slewing && n < 20000) begin
            trig(0);
            n++;
        end
        check("lock_reached", int'(settled), 1);
    endtask

    initial begin
        // reset state
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("rst_out", int'(audio_out), 0);
        check("rst_vld", int'(audio_out_valid), 0);
        check("rst_settled", int'(settled), 1);

        // passthrough after reset
        trig(1000);
        check("pin_pass", int'($signed(audio_out)), 1000);
        check("pin_pass_vld", int'(audio_out_valid), 1);
        idle();
        check("pin_vld_drop", int'(audio_out_valid), 0);
        check("pin_hold", int'($signed(audio_out)), 1000);

        // offset 10 then samples of 100
        cyc(0, 0, 0, 1, 10, 0);
        check("pin_settled_drop", int'(settled), SLEW ? 0 : 1);
        trig(100); check("pin_s1", int'($signed(audio_out)), SLEW ? 100 : 90);
        trig(100); check("pin_s2", int'($signed(audio_out)), SLEW ? 96 : 90);
        trig(100); check("pin_s3", int'($signed(audio_out)), SLEW ? 92 : 90);
        check("pin_s3_settled", int'(settled), 1);
        trig(100); check("pin_s4", int'($signed(audio_out)), 90);
        trig(100); check("pin_s5", int'($signed(audio_out)), 90);

        // saturation both ways
        lock_to(-100);
        trig(32700); check("pin_sat_hi", int'($signed(audio_out)), 32767);
        lock_to(100);
        trig(-32700); check("pin_sat_lo", int'($signed(audio_out)), -32768);

        // offset coincident with trigger
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 50, 1, 8, 0); check("pin_coinc", int'($signed(audio_out)), 50);
        trig(50); check("pin_coinc_next", int'($signed(audio_out)), SLEW ? 50 : 42);
        trig(50); check("pin_coinc_next2", int'($signed(audio_out)), SLEW ? 46 : 42);

        // reset mid-slew
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 20, 0);
        trig(300);
        cyc(1, 0, 0, 0, 0, 0);
        check("pin_rst_out", int'(audio_out), 0);
        check("pin_rst_settled", int'(settled), 1);
        trig(77); check("pin_rst_pass", int'($signed(audio_out)), 77);

        // bypass during slew, then correction with advanced applied
        cyc(0, 0, 0, 1, 40, 0);
        cyc(0, 1, 500, 0, 0, 1); check("pin_byp1", int'($signed(audio_out)), 500);
        cyc(0, 1, 500, 0, 0, 1); check("pin_byp2", int'($signed(audio_out)), 500);
        trig(500); check("pin_byp_off", int'($signed(audio_out)), SLEW ? 492 : 460);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit r, t, ov, bp;
            int ain, off;
            r  = ($urandom_range(0, 199) == 0);
            t  = ($urandom_range(0, 2) != 0);
            ov = ($urandom_range(0, 39) == 0);
            bp = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: ain = $urandom_range(0, 1) ? 32767 : -32768;
                1: ain = int'($urandom_range(0, 400)) - 200;
                default: ain = int'($urandom_range(0, 65535)) - 32768;
            endcase
            case ($urandom_range(0, 3))
                0: off = m_applied;
                1: off = int'($urandom_range(0, 60)) - 30;
                2: off = $urandom_range(0, 1) ? 32767 : -32768;
                default: off = int'($urandom_range(0, 65535)) - 32768;
            endcase
            cyc(r, t, ain, ov, off, bp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
